pipelined_alu: RTL and testbench

- Parametrised, two-stage pipelined N-bit ALU. It is the clocked successor to the combinational ripple ALU slice array in the 3-stage processor datapath.
- Adds a valid/ready handshake on both sides, a persistent flag register (C, V, Z, N), and carry-chained ops (ADC/SBC) that consume the stored carry.
- Sits between the operand-fetch and writeback stages.

---
 rtl/pipelined_alu_if.sv | 30 +++
 rtl/pipelined_alu.sv | 136 +++++++++++++
 tb/tb_pipelined_alu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: handshake and data bundle for the two-stage pipelined ALU.
//   Upstream side : in_valid, in_ready, op, a, b, flag_we
//   Downstream side: out_valid, out_ready, result, res_flags
//   Status        : flags ({C,V,Z,N}, bit 3 = C)
// Modport slave is the ALU side; modport master is the producer/consumer side.
interface pipelined_alu_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         flag_we;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic [3:0]   res_flags;

  modport slave (
    input  in_valid, op, a, b, flag_we, out_ready,
    output in_ready, out_valid, result, flags, res_flags
  );

  modport master (
    output in_valid, op, a, b, flag_we, out_ready,
    input  in_ready, out_valid, result, flags, res_flags
  );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage pipelined N-bit ALU with valid/ready handshakes
// on both sides and a persistent {C,V,Z,N} flag register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipelined_alu_if slave modport (operation in, result out, flags)
// Stage 1 registers the operation; stage 2 computes from the stage-1
// registers and the current flag register and loads result/res_flags.
// Ops reach stage 2 in order, so ADC/SBC see the carry left by the previous
// flag-writing op without any forwarding logic.
module pipelined_alu #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pipelined_alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ADC   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SBC   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // Stage-1 registers
  logic         s1_valid_reg;
  logic [2:0]   s1_op_reg;
  logic [N-1:0] s1_a_reg;
  logic [N-1:0] s1_b_reg;
  logic         s1_flag_we_reg;

  // Stage-2 / architectural registers
  logic         out_valid_reg;
  logic [N-1:0] result_reg;
  logic [3:0]   res_flags_reg;
  logic [3:0]   flags_reg;

  logic         adv2;
  logic         in_xfer;

  // Stage-2 datapath
  logic [N-1:0] b_eff;
  logic         carry_in;
  logic [N:0]   sum_full;
  logic [N-1:0] sum_low;     // sum of the low N-1 bits; its MSB is the carry into bit N-1
  logic [N-1:0] result_next;
  logic         c_next;
  logic         v_next;
  logic [3:0]   res_flags_next;

  // Stage 2 can take a new op when its output slot is empty or being drained.
  assign adv2         = s1_valid_reg && (!out_valid_reg || bus.out_ready);
  assign bus.in_ready = !s1_valid_reg || adv2;
  assign in_xfer      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.res_flags = res_flags_reg;
  assign bus.flags     = flags_reg;

  always_comb begin
    b_eff       = s1_b_reg;
    carry_in    = 1'b0;
    result_next = '0;
    c_next      = 1'b0;
    v_next      = 1'b0;

    // Subtraction is a + ~b + cin; C=1 therefore means "no borrow".
    if (s1_op_reg == OP_SUB || s1_op_reg == OP_SBC) begin
      b_eff = ~s1_b_reg;
    end

    case (s1_op_reg)
      OP_ADC, OP_SBC: carry_in = flags_reg[3];
      OP_SUB:         carry_in = 1'b1;
      default:        carry_in = 1'b0;
    endcase

    sum_full = {1'b0, s1_a_reg} + {1'b0, b_eff} + {{N{1'b0}}, carry_in};
    sum_low  = {1'b0, s1_a_reg[N-2:0]} + {1'b0, b_eff[N-2:0]} + {{(N-1){1'b0}}, carry_in};

    case (s1_op_reg)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        result_next = sum_full[N-1:0];
        c_next      = sum_full[N];
        // Signed overflow: carry out of the MSB differs from carry into it.
        v_next      = sum_full[N] ^ sum_low[N-1];
      end
      OP_AND:   result_next = s1_a_reg & s1_b_reg;
      OP_OR:    result_next = s1_a_reg | s1_b_reg;
      OP_XOR:   result_next = s1_a_reg ^ s1_b_reg;
      OP_PASSB: result_next = s1_b_reg;
      default:  result_next = '0;
    endcase

    res_flags_next = {c_next, v_next, (result_next == '0), result_next[N-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_op_reg      <= '0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_flag_we_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      result_reg     <= '0;
      res_flags_reg  <= '0;
      flags_reg      <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid_reg   <= 1'b1;
        s1_op_reg      <= bus.op;
        s1_a_reg       <= bus.a;
        s1_b_reg       <= bus.b;
        s1_flag_we_reg <= bus.flag_we;
      end else if (adv2) begin
        s1_valid_reg <= 1'b0;
      end

      if (adv2) begin
        out_valid_reg <= 1'b1;
        result_reg    <= result_next;
        res_flags_reg <= res_flags_next;
        if (s1_flag_we_reg) begin
          flags_reg <= res_flags_next;
        end
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed plus randomized check of pipelined_alu (N=8)
// against an arithmetic reference model that predicts each op at accept time.
module tb_pipelined_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_alu_if #(.N(8)) bus ();

  pipelined_alu #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  model_flags = 4'b0;
  logic [15:0] exp_q[$];   // {result, res_flags, flags_after}
  logic [15:0] obs_q[$];   // same packing, as observed at each output transfer

  logic       g_acc;
  logic       g_ov;
  logic       g_ir;
  logic [7:0] g_res;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  task automatic model_push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic fwe);
    int ua, ubm, cin, s_u, sa, sbm, s_s;
    logic [7:0] res;
    logic c, v;
    logic [3:0] rf;
    ua = int'(a);
    ubm = int'(b);
    cin = 0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin ubm = int'(b);       cin = 0; end
      3'd1: begin ubm = int'(b);       cin = int'(model_flags[3]); end
      3'd2: begin ubm = 255 - int'(b); cin = 1; end
      3'd3: begin ubm = 255 - int'(b); cin = int'(model_flags[3]); end
      default: ;
    endcase
    if (op < 3'd4) begin
      s_u = ua + ubm + cin;
      res = s_u[7:0];
      c   = (s_u > 255);
      sa  = (ua  >= 128) ? ua  - 256 : ua;
      sbm = (ubm >= 128) ? ubm - 256 : ubm;
      s_s = sa + sbm + cin;
      v   = (s_s > 127) || (s_s < -128);
    end else if (op == 3'd4) res = a & b;
    else if (op == 3'd5) res = a | b;
    else if (op == 3'd6) res = a ^ b;
    else res = b;
    rf = {c, v, (res == 8'd0), res[7]};
    if (fwe) model_flags = rf;
    exp_q.push_back({res, rf, model_flags});
  endtask

  // One clock cycle: drive at negedge, observe 1 time unit later, then wait for posedge.
  task automatic step(input logic iv, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic fwe, input logic ordy);
    logic [15:0] e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.flag_we   = fwe;
    bus.out_ready = ordy;
    #1;
    g_acc = iv && bus.in_ready;
    g_ov  = bus.out_valid;
    g_ir  = bus.in_ready;
    g_res = bus.result;
    if (bus.out_valid && ordy) begin
      obs_q.push_back({bus.result, bus.res_flags, bus.flags});
      if (exp_q.size() == 0) begin
        chk("spurious_output", {15'd0, bus.out_valid}, 16'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result",    {8'd0, bus.result},     {8'd0, e[15:8]});
        chk("res_flags", {12'd0, bus.res_flags}, {12'd0, e[7:4]});
        chk("flags",     {12'd0, bus.flags},     {12'd0, e[3:0]});
      end
    end
    if (g_acc) model_push(op, a, b, fwe);
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.out_valid); i++)
      step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("drain_timeout", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] last;
    logic [7:0]  held;
    int          base, k;
    logic [2:0]  bp_op[4];
    logic [7:0]  bp_a[4];
    logic [7:0]  bp_b[4];

    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = 8'd0; bus.b = 8'd0;
    bus.flag_we = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_result",    {8'd0, bus.result},     16'd0);
    chk("rst_res_flags", {12'd0, bus.res_flags}, 16'd0);
    chk("rst_flags",     {12'd0, bus.flags},     16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);

    // Signed overflow and latency: out_valid rises on the second edge counting the accept edge
    step(1'b1, 3'd0, 8'h7F, 8'h01, 1'b1, 1'b1);
    chk("lat_accept", {15'd0, g_acc}, 16'd1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat_edge1", {15'd0, g_ov}, 16'd0);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat_edge2", {15'd0, g_ov}, 16'd1);
    drain();
    last = obs_q[$];
    chk("ovf_result", {8'd0, last[15:8]}, 16'h0080);
    chk("ovf_rflags", {12'd0, last[7:4]}, 16'b0101);

    // Carry chain: ADD FF+01 then ADC 00+00 back-to-back
    base = obs_q.size();
    step(1'b1, 3'd0, 8'hFF, 8'h01, 1'b1, 1'b1);
    step(1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b1);
    drain();
    chk("chain_count", 16'(obs_q.size() - base), 16'd2);
    chk("chain_r0",  {8'd0, obs_q[base][15:8]},    16'h0000);
    chk("chain_f0",  {12'd0, obs_q[base][7:4]},    16'b1010);
    chk("chain_r1",  {8'd0, obs_q[base+1][15:8]},  16'h0001);
    chk("chain_fl1", {12'd0, obs_q[base+1][3:0]},  16'b0000);

    // Subtract and borrow
    base = obs_q.size();
    step(1'b1, 3'd2, 8'h05, 8'h05, 1'b1, 1'b1);
    step(1'b1, 3'd2, 8'h03, 8'h05, 1'b1, 1'b1);
    drain();
    chk("sub_r0", {8'd0, obs_q[base][15:8]},   16'h0000);
    chk("sub_f0", {12'd0, obs_q[base][7:4]},   16'b1010);
    chk("sub_r1", {8'd0, obs_q[base+1][15:8]}, 16'h00FE);
    chk("sub_f1", {12'd0, obs_q[base+1][7:4]}, 16'b0001);

    // Flag hold: XOR with flag_we=0 after a flagged ADD leaving C=1
    base = obs_q.size();
    step(1'b1, 3'd0, 8'h80, 8'h80, 1'b1, 1'b1);
    step(1'b1, 3'd6, 8'hAA, 8'hAA, 1'b0, 1'b1);
    drain();
    chk("hold_result", {8'd0, obs_q[base+1][15:8]}, 16'h0000);
    chk("hold_rflagZ", {15'd0, obs_q[base+1][5]},   16'd1);
    chk("hold_flagC",  {15'd0, bus.flags[3]},       16'd1);

    // Backpressure: four ops offered while the consumer stalls
    bp_op[0] = 3'd0; bp_a[0] = 8'h10; bp_b[0] = 8'h20;
    bp_op[1] = 3'd2; bp_a[1] = 8'h50; bp_b[1] = 8'h08;
    bp_op[2] = 3'd5; bp_a[2] = 8'h0F; bp_b[2] = 8'hF0;
    bp_op[3] = 3'd7; bp_a[3] = 8'h00; bp_b[3] = 8'h5A;
    base = obs_q.size();
    k = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, bp_op[k], bp_a[k], bp_b[k], 1'b0, 1'b0);
      if (g_acc) k++;
      if (c == 2) held = g_res;
    end
    chk("bp_accepted", 16'(k), 16'd2);
    chk("bp_in_ready", {15'd0, g_ir}, 16'd0);
    chk("bp_hold",     {8'd0, g_res}, {8'd0, held});
    chk("bp_hold_val", {8'd0, g_res}, 16'h0030);
    for (int c = 0; c < 20 && k < 4; c++) begin
      step(1'b1, bp_op[k], bp_a[k], bp_b[k], 1'b0, 1'b1);
      if (g_acc) k++;
    end
    chk("bp_all_accepted", 16'(k), 16'd4);
    drain();
    chk("bp_count", 16'(obs_q.size() - base), 16'd4);

    // Async reset with two ops in flight
    step(1'b1, 3'd0, 8'h80, 8'h80, 1'b1, 1'b0);
    step(1'b1, 3'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_ov",    {15'd0, bus.out_valid}, 16'd1);
    chk("pre_rst_flags", {12'd0, bus.flags},     16'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("arst_flags",     {12'd0, bus.flags},     16'd0);
    chk("arst_result",    {8'd0, bus.result},     16'd0);
    exp_q.delete();
    model_flags = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = obs_q.size();
    step(1'b1, 3'd1, 8'h01, 8'h01, 1'b1, 1'b1);
    drain();
    chk("post_rst_count", 16'(obs_q.size() - base), 16'd1);
    chk("post_rst_adc",   {8'd0, obs_q[$][15:8]},   16'h0002);

    // Randomized traffic with random stalls on both sides
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), ($urandom % 4) != 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
